sync_fifo_flagged: RTL and testbench

//  Single-clock FIFO with parametrised width and depth. Adds programmable almost-full/almost-empty

---
 rtl/sync_fifo_flagged_if.sv | 37 +++
 rtl/sync_fifo_flagged.sv | 142 ++++++++++++++
 tb/tb_sync_fifo_flagged.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flagged_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_flagged_if
// Handshake, data and status bundle for sync_fifo_flagged.
//   master : producer/consumer side. Drives Write_Enable, Data_In,
//            Read_Enable and Clear_Flags, and observes the rest.
//   slave  : FIFO side. Drives Data_Out, Count and all status flags.
// Clock and reset are not part of the bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface sync_fifo_flagged_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     Write_Enable;
    logic [DATA_WIDTH-1:0]    Data_In;
    logic                     Read_Enable;
    logic                     Clear_Flags;
    logic [DATA_WIDTH-1:0]    Data_Out;
    logic                     Full;
    logic                     Empty;
    logic                     Almost_Full;
    logic                     Almost_Empty;
    logic [ADDRESS_WIDTH:0]   Count;
    logic                     Overflow;
    logic                     Underflow;

    modport master (
        output Write_Enable, Data_In, Read_Enable, Clear_Flags,
        input  Data_Out, Full, Empty, Almost_Full, Almost_Empty,
               Count, Overflow, Underflow
    );

    modport slave (
        input  Write_Enable, Data_In, Read_Enable, Clear_Flags,
        output Data_Out, Full, Empty, Almost_Full, Almost_Empty,
               Count, Overflow, Underflow
    );
endinterface

// File: rtl/sync_fifo_flagged.sv
// ---------------------------------------------------------------------------
// sync_fifo_flagged
// Single-clock FIFO with an occupancy count, programmable almost-full and
// almost-empty thresholds, sticky overflow/underflow flags and a selectable
// first-word-fall-through read mode.
// Ports:
//   Clock         rising-edge clock
//   Reset_Enable  synchronous reset, active low. It clears the pointers,
//                 Count, Data_Out and the error flags; memory is left as is.
//   fifo          sync_fifo_flagged_if.slave. It carries the write and read
//                 requests, the data in both directions, Count and the
//                 Full/Empty/Almost_*/Overflow/Underflow flags.
// ---------------------------------------------------------------------------
module sync_fifo_flagged #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int DATA_DEPTH         = 16,
    parameter int ALMOST_FULL_LEVEL  = 14,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int FWFT               = 0
) (
    input  logic               Clock,
    input  logic               Reset_Enable,
    sync_fifo_flagged_if.slave fifo
);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_COUNT = (ADDRESS_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AF_LEVEL    = (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] AE_LEVEL    = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    // Pointers carry one extra bit and wrap modulo twice the depth; only the
    // low bits address the memory.
    logic [ADDRESS_WIDTH:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDRESS_WIDTH:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDRESS_WIDTH:0] count_reg, count_next;
    logic                   overflow_reg, overflow_next;
    logic                   underflow_reg, underflow_next;

    logic full;
    logic empty;
    logic wr_accept;
    logic rd_accept;
    logic [ADDRESS_WIDTH-1:0] rd_idx;
    logic [ADDRESS_WIDTH-1:0] wr_idx;

    // All flags come from the registered count, so they describe the state
    // before the coming edge. Acceptance is decided from that state.
    assign full   = (count_reg == DEPTH_COUNT);
    assign empty  = (count_reg == '0);
    assign rd_idx = rd_ptr_reg[ADDRESS_WIDTH-1:0];
    assign wr_idx = wr_ptr_reg[ADDRESS_WIDTH-1:0];

    always_comb begin
        wr_accept      = fifo.Write_Enable && !full;
        rd_accept      = fifo.Read_Enable && !empty;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        // A simultaneous accepted read and write leave the count unchanged.
        if (wr_accept && !rd_accept) begin
            count_next = count_reg + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_next = count_reg - 1'b1;
        end

        // The clear is applied first so that an error in the same cycle
        // overrides it.
        if (fifo.Clear_Flags) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (fifo.Write_Enable && full) begin
            overflow_next = 1'b1;
        end
        if (fifo.Read_Enable && empty) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_Enable) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // The storage has no reset. A write that coincides with reset is dropped,
    // because the pointers are reset and the data is discarded anyway.
    always_ff @(posedge Clock) begin
        if (Reset_Enable && wr_accept) begin
            mem[wr_idx] <= fifo.Data_In;
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            // Registered read. The output holds between reads and while the
            // FIFO is empty.
            logic [DATA_WIDTH-1:0] data_out_reg;
            always_ff @(posedge Clock) begin
                if (!Reset_Enable) begin
                    data_out_reg <= '0;
                end else if (rd_accept) begin
                    data_out_reg <= mem[rd_idx];
                end
            end
            assign fifo.Data_Out = data_out_reg;
        end else begin : g_fwft_read
            // The head word is presented directly from the memory. The
            // output is forced to zero while the FIFO is empty, so stale
            // entries are never shown.
            assign fifo.Data_Out = empty ? '0 : mem[rd_idx];
        end
    endgenerate

    assign fifo.Count        = count_reg;
    assign fifo.Full         = full;
    assign fifo.Empty        = empty;
    assign fifo.Almost_Full  = (count_reg >= AF_LEVEL);
    assign fifo.Almost_Empty = (count_reg <= AE_LEVEL);
    assign fifo.Overflow     = overflow_reg;
    assign fifo.Underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Two instances receive identical stimulus: one in registered-read mode and
// one in first-word-fall-through mode. The reference is a queue of words plus
// the two sticky flags and the last word popped.
module tb_sync_fifo_flagged;
    logic Clock;
    logic Reset_Enable;

    sync_fifo_flagged_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) if0 ();
    sync_fifo_flagged_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) if1 ();

    sync_fifo_flagged #(.FWFT(0)) dut0 (
        .Clock(Clock), .Reset_Enable(Reset_Enable), .fifo(if0.slave)
    );
    sync_fifo_flagged #(.FWFT(1)) dut1 (
        .Clock(Clock), .Reset_Enable(Reset_Enable), .fifo(if1.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_q[$];
    logic       model_ovf;
    logic       model_unf;
    logic [7:0] model_dout;

    function automatic logic [18:0] obs_vec(input bit fwft);
        if (fwft)
            return {if1.Data_Out, if1.Full, if1.Empty, if1.Almost_Full,
                    if1.Almost_Empty, if1.Count, if1.Overflow, if1.Underflow};
        return {if0.Data_Out, if0.Full, if0.Empty, if0.Almost_Full,
                if0.Almost_Empty, if0.Count, if0.Overflow, if0.Underflow};
    endfunction

    function automatic logic [18:0] exp_vec(input bit fwft);
        int n;
        logic [7:0] d;
        n = model_q.size();
        if (fwft) d = (n != 0) ? model_q[0] : 8'h00;
        else      d = model_dout;
        return {d, (n == 16), (n == 0), (n >= 14), (n <= 2), 5'(n), model_ovf, model_unf};
    endfunction

    // Drive one cycle of requests into both FIFOs and advance the model.
    // Outputs are sampled 1 time unit after the clock edge.
    task automatic apply(input bit we, input logic [7:0] din, input bit re, input bit clr);
        bit was_full, was_empty;
        @(negedge Clock);
        if0.Write_Enable = we;  if1.Write_Enable = we;
        if0.Data_In      = din; if1.Data_In      = din;
        if0.Read_Enable  = re;  if1.Read_Enable  = re;
        if0.Clear_Flags  = clr; if1.Clear_Flags  = clr;
        @(posedge Clock);
        #1;
        was_full  = (model_q.size() == 16);
        was_empty = (model_q.size() == 0);
        if (re && !was_empty) model_dout = model_q.pop_front();
        if (we && !was_full)  model_q.push_back(din);
        if (clr) begin model_ovf = 1'b0; model_unf = 1'b0; end
        if (we && was_full)  model_ovf = 1'b1;
        if (re && was_empty) model_unf = 1'b1;
        @(negedge Clock);
        if0.Write_Enable = 1'b0; if1.Write_Enable = 1'b0;
        if0.Read_Enable  = 1'b0; if1.Read_Enable  = 1'b0;
        if0.Clear_Flags  = 1'b0; if1.Clear_Flags  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clock);
        Reset_Enable = 1'b0;
        @(posedge Clock);
        #1;
        model_q.delete();
        model_ovf  = 1'b0;
        model_unf  = 1'b0;
        model_dout = 8'h00;
        @(negedge Clock);
        Reset_Enable = 1'b1;
    endtask

    task automatic test_reset();
        pulse_reset();
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs_vec(m[0]) !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset fwft=%0d: got %h expected %h", m,
                         obs_vec(m[0]), {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0});
            end
        end
        $display("reset: count0=%0d count1=%0d", if0.Count, if1.Count);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 8'(i), 1'b0, 1'b0);
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs_vec(m[0]) !== exp_vec(m[0])) begin
                    miscompares++;
                    $display("FAIL fill[%0d] fwft=%0d: got %h expected %h", i, m,
                             obs_vec(m[0]), exp_vec(m[0]));
                end
            end
            $display("fill write %h: count=%0d af=%b ae=%b", 8'(i), if0.Count,
                     if0.Almost_Full, if0.Almost_Empty);
        end
        vectors++;
        if ({if0.Count, if0.Full, if1.Count, if1.Full} !== {5'd16, 1'b1, 5'd16, 1'b1}) begin
            miscompares++;
            $display("FAIL fill_full: got %0d/%b %0d/%b expected 16/1", if0.Count,
                     if0.Full, if1.Count, if1.Full);
        end
    endtask

    task automatic test_overflow();
        apply(1'b1, 8'hAA, 1'b0, 1'b0);
        vectors++;
        if ({if0.Overflow, if0.Count, if1.Overflow, if1.Count} !== {1'b1, 5'd16, 1'b1, 5'd16}) begin
            miscompares++;
            $display("FAIL overflow_set: got ovf=%b cnt=%0d expected ovf=1 cnt=16",
                     if0.Overflow, if0.Count);
        end
        $display("overflow write AA: ovf=%b count=%0d", if0.Overflow, if0.Count);
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if ({if0.Overflow, if1.Overflow} !== 2'b00) begin
            miscompares++;
            $display("FAIL overflow_clear: got %b%b expected 00", if0.Overflow, if1.Overflow);
        end
        $display("clear flags: ovf=%b", if0.Overflow);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (if0.Data_Out !== 8'(i)) begin
                miscompares++;
                $display("FAIL drain[%0d]: got %h expected %h", i, if0.Data_Out, 8'(i));
            end
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs_vec(m[0]) !== exp_vec(m[0])) begin
                    miscompares++;
                    $display("FAIL drain_state[%0d] fwft=%0d: got %h expected %h", i, m,
                             obs_vec(m[0]), exp_vec(m[0]));
                end
            end
            $display("drain read: data=%h count=%0d", if0.Data_Out, if0.Count);
        end
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if ({if0.Underflow, if0.Data_Out, if0.Count} !== {1'b1, 8'h0F, 5'd0}) begin
            miscompares++;
            $display("FAIL underflow: got unf=%b data=%h cnt=%0d expected unf=1 data=0f cnt=0",
                     if0.Underflow, if0.Data_Out, if0.Count);
        end
        $display("extra read: unf=%b data=%h", if0.Underflow, if0.Data_Out);
    endtask

    task automatic test_fwft();
        apply(1'b0, 8'h00, 1'b0, 1'b1);
        apply(1'b1, 8'h5A, 1'b0, 1'b0);
        vectors++;
        if ({if1.Data_Out, if1.Empty} !== {8'h5A, 1'b0}) begin
            miscompares++;
            $display("FAIL fwft_write: got data=%h empty=%b expected 5a/0", if1.Data_Out, if1.Empty);
        end
        $display("fwft write 5A: data=%h empty=%b", if1.Data_Out, if1.Empty);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if ({if1.Data_Out, if1.Empty, if1.Underflow} !== {8'h00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL fwft_read: got data=%h empty=%b unf=%b expected 00/1/0",
                     if1.Data_Out, if1.Empty, if1.Underflow);
        end
        vectors++;
        if (if0.Data_Out !== 8'h5A) begin
            miscompares++;
            $display("FAIL std_read_5a: got %h expected 5a", if0.Data_Out);
        end
        $display("fwft read: data=%h empty=%b", if1.Data_Out, if1.Empty);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) apply(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            apply(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            vectors++;
            if (if0.Count !== 5'd8 || if1.Count !== 5'd8) begin
                miscompares++;
                $display("FAIL b2b_count[%0d]: got %0d/%0d expected 8", i, if0.Count, if1.Count);
            end
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs_vec(m[0]) !== exp_vec(m[0])) begin
                    miscompares++;
                    $display("FAIL b2b[%0d] fwft=%0d: got %h expected %h", i, m,
                             obs_vec(m[0]), exp_vec(m[0]));
                end
            end
            $display("b2b cycle %0d: out0=%h out1=%h count=%0d", i, if0.Data_Out,
                     if1.Data_Out, if0.Count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) apply(1'b0, 8'h00, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 1'b1, 1'b1);
        apply(1'b1, 8'h11, 1'b0, 1'b0);
        vectors++;
        if (if0.Count !== 5'd5) begin
            miscompares++;
            $display("FAIL pre_reset_count: got %0d expected 5", if0.Count);
        end
        pulse_reset();
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs_vec(m[0]) !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL mid_reset fwft=%0d: got %h expected empty/zero", m, obs_vec(m[0]));
            end
        end
        apply(1'b1, 8'hC3, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if ({if0.Data_Out, if0.Empty, if1.Empty} !== {8'hC3, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL post_reset_data: got %h empty=%b expected c3/1", if0.Data_Out, if0.Empty);
        end
        $display("reset mid-stream: new data %h", if0.Data_Out);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (obs_vec(m[0]) !== exp_vec(m[0])) begin
                    miscompares++;
                    $display("FAIL random[%0d] fwft=%0d: got %h expected %h", i, m,
                             obs_vec(m[0]), exp_vec(m[0]));
                end
            end
            $display("random %0d: count=%0d out0=%h out1=%h ovf=%b unf=%b", i, if0.Count,
                     if0.Data_Out, if1.Data_Out, if0.Overflow, if0.Underflow);
        end
    endtask

    initial begin
        Reset_Enable = 1'b1;
        if0.Write_Enable = 1'b0; if1.Write_Enable = 1'b0;
        if0.Data_In      = 8'h00; if1.Data_In     = 8'h00;
        if0.Read_Enable  = 1'b0; if1.Read_Enable  = 1'b0;
        if0.Clear_Flags  = 1'b0; if1.Clear_Flags  = 1'b0;
        model_ovf  = 1'b0;
        model_unf  = 1'b0;
        model_dout = 8'h00;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_fwft();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
